ifetch: RTL

Instruction fetch unit for the MIPS core. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents one instruction at a time to the decode stage over a valid/ready handshake. It is the producer side of the decoder's `inst` input and the consumer of the decoder's `npc_op`/`imm` outputs. Redirects for J, JAL, JR and taken branches squash wrong-path work; the core has no branch delay slots.

---
 rtl/ifetch_pkg.sv | 17 +
 rtl/ifetch_npc_calc.sv | 55 +++++
 rtl/ifetch.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: definitions shared by the instruction fetch unit.
//   - NPC_* : next-PC operation encodings. Decode drives the same values.
//   - fetch_state_e : fetch sequencer states.
package ifetch_pkg;

  localparam logic [2:0] NPC_PC4 = 3'b000;
  localparam logic [2:0] NPC_B   = 3'b010;
  localparam logic [2:0] NPC_J   = 3'b011;
  localparam logic [2:0] NPC_JR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request outstanding
    ST_WAIT = 2'd1,  // request outstanding, waiting for imem_ack
    ST_HALT = 2'd2   // fatal address error; frozen until reset
  } fetch_state_e;

endpackage

// File: rtl/ifetch_npc_calc.sv
// npc_calc: combinational redirect target computation for the fetch unit.
// Ports:
//   last_pc     in  32 : PC of the last instruction handed to decode
//   npc_op      in   3 : next-PC operation from decode
//   br_taken    in   1 : branch condition; only meaningful for NPC_B
//   imm         in  32 : B: sign-extended word offset, J: instr_index in [25:0]
//   jr_target   in  32 : register value for JR
//   redirect_en out  1 : the operation changes the fetch stream
//   target      out 32 : new fetch PC when redirect_en=1
//   misaligned  out  1 : JR to a non-word-aligned address
module npc_calc
  import ifetch_pkg::*;
(
  input  logic [31:0] last_pc,
  input  logic [2:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] imm,
  input  logic [31:0] jr_target,
  output logic        redirect_en,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] seq_pc;

  // No delay slots: all relative targets are based on the instruction
  // following the control-flow instruction.
  assign seq_pc = last_pc + 32'd4;

  always_comb begin
    redirect_en = 1'b0;
    target      = seq_pc;
    misaligned  = 1'b0;
    case (npc_op)
      NPC_B: begin
        if (br_taken) begin
          redirect_en = 1'b1;
          target      = seq_pc + (imm << 2);
        end
      end
      NPC_J: begin
        redirect_en = 1'b1;
        target      = {seq_pc[31:28], imm[25:0], 2'b00};
      end
      NPC_JR: begin
        // A misaligned JR is reported as an error instead of a redirect.
        misaligned  = (jr_target[1:0] != 2'b00);
        redirect_en = !misaligned;
        target      = jr_target;
      end
      default: ;  // PC4 and undefined codes: sequential fetch is correct
    endcase
  end

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit. Owns the PC, reads instruction memory
// one word at a time over req/ack, and presents instructions to decode
// over valid/ready. Control-flow redirects from decode squash wrong-path
// work, including a request already in flight.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   imem_req/addr       : registered read request and its word address
//   imem_ack/rdata      : read completion and instruction word
//   inst/inst_pc        : instruction and its PC for decode
//   inst_valid/ready    : output handshake
//   redirect_valid      : decode reports control flow for last accepted inst
//   npc_op/br_taken/imm/jr_target : redirect description from decode
//   addr_err            : sticky misaligned-JR flag
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [2:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] imm,
  input  logic [31:0] jr_target,
  output logic        addr_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;
  logic         kill_q, kill_d;
  logic [31:0]  last_pc_q, last_pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;
  logic         addr_err_q, addr_err_d;

  logic         redirect_en;
  logic [31:0]  target;
  logic         misaligned;
  logic         transfer;
  logic         do_redirect;
  logic         do_error;

  npc_calc u_npc_calc (
    .last_pc     (last_pc_q),
    .npc_op      (npc_op),
    .br_taken    (br_taken),
    .imm         (imm),
    .jr_target   (jr_target),
    .redirect_en (redirect_en),
    .target      (target),
    .misaligned  (misaligned)
  );

  assign transfer    = inst_valid_q && inst_ready;
  assign do_redirect = redirect_valid && redirect_en && (state_q != ST_HALT);
  assign do_error    = redirect_valid && misaligned && (state_q != ST_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      kill_q       <= 1'b0;
      last_pc_q    <= 32'h0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      kill_q       <= kill_d;
      last_pc_q    <= last_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    last_pc_d    = last_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    addr_err_d   = addr_err_q;

    if (transfer) begin
      inst_valid_d = 1'b0;
      last_pc_d    = inst_pc_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        // Only fetch when the output slot will have room for the result.
        if (!inst_valid_q || inst_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_ack) begin
          state_d = ST_IDLE;
          if (kill_q) begin
            kill_d = 1'b0;  // stale response for a squashed request
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase

    // Redirects and errors override any capture or transfer above.
    if (do_error) begin
      addr_err_d   = 1'b1;
      inst_valid_d = 1'b0;
      state_d      = ST_HALT;
      kill_d       = 1'b0;
      pc_d         = pc_q;
      last_pc_d    = last_pc_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
    end else if (do_redirect) begin
      pc_d         = target;
      inst_valid_d = 1'b0;
      last_pc_d    = last_pc_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      if (state_q == ST_WAIT) begin
        if (imem_ack) begin
          state_d = ST_IDLE;   // response in the redirect cycle is dropped
          kill_d  = 1'b0;
        end else begin
          state_d = ST_WAIT;   // keep the request up until its ack drains
          kill_d  = 1'b1;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // The address is frozen for the whole request, even when a redirect
  // moves pc while a killed request is still outstanding.
  always_comb begin
    req_d  = (state_d == ST_WAIT);
    addr_d = (state_q == ST_WAIT) ? addr_q : pc_d;
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign addr_err   = addr_err_q;

endmodule
